// File: rtl/dm_port_arbiter_if.sv
// Requester-side bundle for the two data-memory port clients (0 = core LSU, 1 = host/DMA).
interface dm_port_arbiter_if;
   logic        req0;
   logic        req1;
   logic        we0;
   logic        we1;
   logic [15:0] addr0;
   logic [15:0] addr1;
   logic [31:0] wdata0;
   logic [31:0] wdata1;
   logic        gnt0;
   logic        gnt1;
   logic        rvalid0;
   logic        rvalid1;
   logic [31:0] rdata0;
   logic [31:0] rdata1;
   logic        err0;
   logic        err1;

   // Requester view: drives requests, receives grants and returns.
   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
   );

   // Arbiter view.
   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
   );
endinterface

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter sharing the banked data-memory port between core and host/DMA,
// with a fixed-latency return pipe that routes read data / error strobes to the owner.
module dm_port_arbiter #(
   parameter int unsigned RD_LAT  = 1,
   parameter logic [3:0]  MAX_SEL = 4'h2
) (
   input  logic                    clk,
   input  logic                    reset_n,
   dm_port_arbiter_if.slave        bus,
   output logic                    mem_wren,
   output logic [15:0]             mem_address,
   output logic [31:0]             mem_data,
   input  logic [31:0]             mem_q
);

   localparam int unsigned DEPTH = RD_LAT + 1;
   localparam int unsigned AW    = 16;
   localparam int unsigned DW    = 32;

   typedef struct packed {
      logic valid;
      logic id;
      logic is_read;
      logic is_err;
   } ret_t;

   logic            last_gnt;
   ret_t            pipe [DEPTH];
   logic            gnt0_c;
   logic            gnt1_c;
   logic            gnt_any_c;
   logic            sel_id_c;
   logic            sel_we_c;
   logic            sel_legal_c;
   logic [AW-1:0]   sel_addr_c;
   logic [DW-1:0]   sel_wdata_c;
   ret_t            push_c;
   ret_t            slot_c;

   // Round-robin grant; the requester that did not win last time takes a tie.
   always_comb begin
      gnt0_c = 1'b0;
      gnt1_c = 1'b0;
      if (reset_n) begin
         gnt0_c = bus.req0 & (~bus.req1 | last_gnt);
         gnt1_c = bus.req1 & (~bus.req0 | ~last_gnt);
      end
   end

   assign bus.gnt0 = gnt0_c;
   assign bus.gnt1 = gnt1_c;

   // Mux the granted request and classify it for the return pipe.
   always_comb begin
      gnt_any_c   = gnt0_c | gnt1_c;
      sel_id_c    = gnt1_c;
      sel_we_c    = gnt1_c ? bus.we1    : bus.we0;
      sel_addr_c  = gnt1_c ? bus.addr1  : bus.addr0;
      sel_wdata_c = gnt1_c ? bus.wdata1 : bus.wdata0;
      sel_legal_c = (sel_addr_c[15:12] <= MAX_SEL);
      push_c         = '0;
      push_c.valid   = gnt_any_c;
      push_c.id      = sel_id_c;
      push_c.is_read = ~sel_we_c;
      push_c.is_err  = ~sel_legal_c;
   end

   // Arbitration history, registered memory command and return pipe shift.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         last_gnt    <= 1'b1;
         mem_wren    <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         if (gnt_any_c) begin
            last_gnt    <= sel_id_c;
            mem_address <= sel_addr_c;
            mem_data    <= sel_wdata_c;
         end
         mem_wren <= gnt_any_c & sel_we_c & sel_legal_c;
         pipe[0]  <= push_c;
         for (int unsigned i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Decode the emerging slot into per-requester strobes; read data passes straight through.
   always_comb begin
      slot_c      = pipe[DEPTH-1];
      bus.rvalid0 = slot_c.valid & ~slot_c.id & slot_c.is_read;
      bus.rvalid1 = slot_c.valid &  slot_c.id & slot_c.is_read;
      bus.err0    = slot_c.valid & ~slot_c.id & slot_c.is_err;
      bus.err1    = slot_c.valid &  slot_c.id & slot_c.is_err;
      bus.rdata0  = (slot_c.valid & ~slot_c.id & slot_c.is_read & ~slot_c.is_err) ? mem_q : '0;
      bus.rdata1  = (slot_c.valid &  slot_c.id & slot_c.is_read & ~slot_c.is_err) ? mem_q : '0;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed accesses push expected returns,
// a negedge monitor pops and compares every return strobe.
module tb_dm_port_arbiter;

   typedef struct {
      int          cyc;
      logic        rv;
      logic        er;
      logic [31:0] data;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        mem_wren;
   logic [15:0] mem_address;
   logic [31:0] mem_data;
   logic [31:0] mem_q;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   exp_t q0[$];
   exp_t q1[$];
   logic [31:0] mem [logic [15:0]];

   dm_port_arbiter_if bus ();

   dm_port_arbiter #(.RD_LAT(1), .MAX_SEL(4'h2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .bus         (bus),
      .mem_wren    (mem_wren),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_q       (mem_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rd_mem(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return {16'hC0DE, a};
   endfunction

   // One-cycle read latency memory model.
   always @(posedge clk) begin
      mem_q <= rd_mem(mem_address);
      if (mem_wren === 1'b1) mem[mem_address] = mem_data;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, got, exp);
      end
   endtask

   task automatic mon_port(input bit id, input logic rv, input logic er, input logic [31:0] rd);
      exp_t e;
      bit   have;
      have = id ? (q1.size() > 0) : (q0.size() > 0);
      if (have) e = id ? q1[0] : q0[0];
      if (rv === 1'b1 || er === 1'b1) begin
         if (!have) begin
            checks++;
            errors++;
            $display("FAIL ret%0d_unexpected @cyc %0d: got rvalid=%b err=%b rdata=%h expected no strobe",
                     id, cyc, rv, er, rd);
         end else begin
            if (id) void'(q1.pop_front()); else void'(q0.pop_front());
            chk($sformatf("ret%0d_cyc", id),    32'(cyc), 32'(e.cyc));
            chk($sformatf("ret%0d_rvalid", id), 32'(rv),  32'(e.rv));
            chk($sformatf("ret%0d_err", id),    32'(er),  32'(e.er));
            chk($sformatf("ret%0d_rdata", id),  rd,       e.data);
         end
      end else if (have && e.cyc <= cyc) begin
         checks++;
         errors++;
         $display("FAIL ret%0d_missing @cyc %0d: got no strobe expected strobe at cyc %0d",
                  id, cyc, e.cyc);
         if (id) void'(q1.pop_front()); else void'(q0.pop_front());
      end
   endtask

   // Return monitor.
   always @(negedge clk) begin
      mon_port(1'b0, bus.rvalid0, bus.err0, bus.rdata0);
      mon_port(1'b1, bus.rvalid1, bus.err1, bus.rdata1);
   end

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic gnt_chk(input logic g0, input logic g1);
      @(negedge clk);
      chk("gnt0", 32'(bus.gnt0), 32'(g0));
      chk("gnt1", 32'(bus.gnt1), 32'(g1));
   endtask

   task automatic exp_ret(input bit id, input logic rv, input logic er, input logic [31:0] d);
      exp_t e;
      e.cyc  = cyc + 2;
      e.rv   = rv;
      e.er   = er;
      e.data = d;
      if (id) q1.push_back(e); else q0.push_back(e);
   endtask

   task automatic drive(input bit id, input logic we, input logic [15:0] a, input logic [31:0] d);
      if (id) begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end else begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end
   endtask

   task automatic idle_all();
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_mem_wren"},    32'(mem_wren),    32'd0);
      chk({tag, "_mem_address"}, 32'(mem_address), 32'd0);
      chk({tag, "_mem_data"},    mem_data,         32'd0);
      chk({tag, "_rvalid0"},     32'(bus.rvalid0), 32'd0);
      chk({tag, "_rvalid1"},     32'(bus.rvalid1), 32'd0);
      chk({tag, "_err0"},        32'(bus.err0),    32'd0);
      chk({tag, "_err1"},        32'(bus.err1),    32'd0);
   endtask

   initial begin
      mem[16'h0000] = 32'h11110000;
      mem[16'h0001] = 32'h22221111;
      mem[16'h0002] = 32'h33332222;
      mem[16'h0004] = 32'hA1B2C3D4;
      reset_n = 1'b0;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      repeat (3) next_cyc();

      // Reset state: requests are ignored while reset_n is low.
      bus.req0 = 1'b1;
      gnt_chk(1'b0, 1'b0);
      chk_reset_outputs("reset");
      next_cyc();
      idle_all();
      reset_n = 1'b1;

      // Test 2: both requesters held from reset -> 0,1,0,1.
      drive(1'b0, 1'b0, 16'h0000, 32'h0);
      drive(1'b1, 1'b0, 16'h1000, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'h11110000); next_cyc();
      gnt_chk(1'b0, 1'b1); exp_ret(1'b1, 1'b1, 1'b0, 32'hC0DE1000);
      chk("t2_mem_address_a", 32'(mem_address), 32'h0000_0000);
      next_cyc();
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'h11110000);
      chk("t2_mem_address_b", 32'(mem_address), 32'h0000_1000);
      next_cyc();
      gnt_chk(1'b0, 1'b1); exp_ret(1'b1, 1'b1, 1'b0, 32'hC0DE1000); next_cyc();
      idle_all();
      gnt_chk(1'b0, 1'b0); next_cyc();
      repeat (3) next_cyc();

      // Test 1: single read, data returned two cycles after grant.
      drive(1'b0, 1'b0, 16'h0004, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'hA1B2C3D4); next_cyc();
      idle_all();
      gnt_chk(1'b0, 1'b0);
      chk("t1_mem_address", 32'(mem_address), 32'h0000_0004);
      chk("t1_mem_wren",    32'(mem_wren),    32'd0);
      next_cyc();
      repeat (2) next_cyc();

      // Test 3: legal write by requester 1, no return strobe.
      drive(1'b1, 1'b1, 16'h1010, 32'h00000055);
      gnt_chk(1'b0, 1'b1); next_cyc();
      idle_all();
      gnt_chk(1'b0, 1'b0);
      chk("t3_mem_wren",    32'(mem_wren),    32'd1);
      chk("t3_mem_address", 32'(mem_address), 32'h0000_1010);
      chk("t3_mem_data",    mem_data,         32'h00000055);
      next_cyc();
      @(negedge clk);
      chk("t3_mem_wren_pulse", 32'(mem_wren), 32'd0);
      chk("t3_mem_address_hold", 32'(mem_address), 32'h0000_1010);
      next_cyc();
      repeat (2) next_cyc();

      // Test 4: read of an illegal region -> error return with zero data.
      drive(1'b0, 1'b0, 16'h3000, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b1, 32'h0); next_cyc();
      idle_all();
      gnt_chk(1'b0, 1'b0);
      chk("t4_mem_wren", 32'(mem_wren), 32'd0);
      next_cyc();
      repeat (2) next_cyc();

      // Region boundary: highest legal region read, illegal write, top region read.
      drive(1'b1, 1'b0, 16'h2008, 32'h0);
      gnt_chk(1'b0, 1'b1); exp_ret(1'b1, 1'b1, 1'b0, 32'hC0DE2008); next_cyc();
      drive(1'b1, 1'b1, 16'h3004, 32'h00000077);
      gnt_chk(1'b0, 1'b1); exp_ret(1'b1, 1'b0, 1'b1, 32'h0); next_cyc();
      idle_all();
      drive(1'b0, 1'b0, 16'hF000, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b1, 32'h0);
      chk("bnd_illegal_wr_wren", 32'(mem_wren), 32'd0);
      chk("bnd_illegal_wr_addr", 32'(mem_address), 32'h0000_3004);
      next_cyc();
      idle_all();
      repeat (3) next_cyc();

      // Test 5: back-to-back reads from requester 0.
      drive(1'b0, 1'b0, 16'h0000, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'h11110000); next_cyc();
      drive(1'b0, 1'b0, 16'h0001, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'h22221111); next_cyc();
      drive(1'b0, 1'b0, 16'h0002, 32'h0);
      gnt_chk(1'b1, 1'b0); exp_ret(1'b0, 1'b1, 1'b0, 32'h33332222); next_cyc();
      idle_all();
      repeat (4) next_cyc();

      // Test 6: reset immediately after a grant discards the in-flight read.
      drive(1'b0, 1'b0, 16'h0001, 32'h0);
      gnt_chk(1'b1, 1'b0); next_cyc();
      reset_n = 1'b0;
      idle_all();
      gnt_chk(1'b0, 1'b0); next_cyc();
      @(negedge clk);
      chk_reset_outputs("t6");
      next_cyc();
      reset_n = 1'b1;
      repeat (4) next_cyc();

      @(negedge clk);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
